// File: rtl/addsub_pkg.sv
// Shared definitions for the chunked add/subtract unit: FSM state encoding
// and the chunk-counter width helper.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter must still be one bit wide when the whole word is a single slice.
    function automatic int cnt_width(input int width, input int chunk);
        int n;
        n = width / chunk;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// One CHUNK-bit slice of the adder: optional inversion of y followed by a
// ripple add with carry-in; also exposes the carry into the slice MSB.
module addsub_chunk
    import addsub_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             sub,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK-1:0] y_inv;
    logic [CHUNK:0]   sum;

    assign y_inv = y ^ {CHUNK{sub}};
    assign sum   = {1'b0, x} + {1'b0, y_inv} + {{CHUNK{1'b0}}, cin};
    assign s     = sum[CHUNK-1:0];
    assign cout  = sum[CHUNK];
    // The MSB sum bit is x ^ y ^ carry-in, so the carry-in can be recovered.
    assign c_msb_in = s[CHUNK-1] ^ x[CHUNK-1] ^ y_inv[CHUNK-1];

endmodule

// File: rtl/addsub_chunked_seq.sv
// Multi-cycle signed add/subtract, one CHUNK-bit slice per clock, with
// valid/ready handshakes and carry/overflow/zero flags.
// Optional signed saturation on overflow: define ADDSUB_SAT_EN.
module addsub_chunked_seq
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = cnt_width(WIDTH, CHUNK);
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q, result_q;
    logic             sub_q, carry_q;
    logic [CW-1:0]    cnt_q;
    logic             cout_q, ovf_q, zero_q;

    int unsigned      base;
    logic [CHUNK-1:0] slice_s;
    logic             slice_cout, slice_cmsb;
    logic [WIDTH-1:0] result_d, final_d;
    logic             ovf_d;

    assign base = 32'(cnt_q) * CHUNK;

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .x        (a_q[base +: CHUNK]),
        .y        (b_q[base +: CHUNK]),
        .sub      (sub_q),
        .cin      (carry_q),
        .s        (slice_s),
        .cout     (slice_cout),
        .c_msb_in (slice_cmsb)
    );

`ifdef ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(1) << (WIDTH - 1);
    localparam logic [WIDTH-1:0] SAT_MAX = ~SAT_MIN;
`endif

    // final_d only matters on the last slice, where ovf_d is meaningful.
    always_comb begin
        result_d = result_q;
        result_d[base +: CHUNK] = slice_s;
        ovf_d = slice_cmsb ^ slice_cout;
`ifdef ADDSUB_SAT_EN
        if (ovf_d)
            final_d = a_q[WIDTH-1] ? SAT_MIN : SAT_MAX;
        else
            final_d = result_d;
`else
        final_d = result_d;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        sub_q   <= sub;
                        carry_q <= sub;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    result_q <= result_d;
                    carry_q  <= slice_cout;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        result_q <= final_d;
                        cout_q   <= slice_cout;
                        ovf_q    <= ovf_d;
                        zero_q   <= (final_d == '0);
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_addsub_chunked_seq.sv
// Self-checking bench for addsub_chunked_seq: directed cases on a 16/4 build,
// random sweeps on 8/8 and 32/1 builds, all against an arithmetic model.
module tb_addsub_chunked_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic        in_valid16 = 0, sub16 = 0, out_ready16 = 1;
    logic [15:0] a16 = 0, b16 = 0;
    logic        in_ready16, out_valid16, cout16, ovf16, zero16;
    logic [15:0] result16;

    logic        in_valid8 = 0, sub8 = 0, out_ready8 = 1;
    logic [7:0]  a8 = 0, b8 = 0;
    logic        in_ready8, out_valid8, cout8, ovf8, zero8;
    logic [7:0]  result8;

    logic        in_valid32 = 0, sub32 = 0, out_ready32 = 1;
    logic [31:0] a32 = 0, b32 = 0;
    logic        in_ready32, out_valid32, cout32, ovf32, zero32;
    logic [31:0] result32;

    addsub_chunked_seq #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .sub(sub16), .a(a16), .b(b16), .out_valid(out_valid16),
        .out_ready(out_ready16), .result(result16), .cout(cout16),
        .ovf(ovf16), .zero(zero16));

    addsub_chunked_seq #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .sub(sub8), .a(a8), .b(b8), .out_valid(out_valid8),
        .out_ready(out_ready8), .result(result8), .cout(cout8),
        .ovf(ovf8), .zero(zero8));

    addsub_chunked_seq #(.WIDTH(32), .CHUNK(1)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
        .sub(sub32), .a(a32), .b(b32), .out_valid(out_valid32),
        .out_ready(out_ready32), .result(result32), .cout(cout32),
        .ovf(ovf32), .zero(zero32));

    // Reference: true signed value decides overflow, unsigned compare decides carry.
    function automatic void model(input int w, input longint unsigned av, input longint unsigned bv,
                                  input bit sb, output longint unsigned res,
                                  output bit co, output bit ov, output bit z);
        longint unsigned mask, half;
        longint sa, sbs, tr;
        mask = (64'd1 << w) - 1;
        half = 64'd1 << (w - 1);
        res  = (sb ? (av - bv) : (av + bv)) & mask;
        co   = sb ? (av >= bv) : ((av + bv) > mask);
        sa   = (av >= half) ? longint'(av) - longint'(mask + 1) : longint'(av);
        sbs  = (bv >= half) ? longint'(bv) - longint'(mask + 1) : longint'(bv);
        tr   = sb ? (sa - sbs) : (sa + sbs);
        ov   = (tr > longint'(half) - 1) || (tr < -longint'(half));
`ifdef ADDSUB_SAT_EN
        if (ov) res = (sa < 0) ? half : half - 1;
`endif
        z = (res == 0);
    endfunction

    // Present one operation, scramble inputs after accept, wait for out_valid.
    task automatic op16(input logic [15:0] av, input logic [15:0] bv, input logic sv, output int lat);
        a16 = av; b16 = bv; sub16 = sv; in_valid16 = 1;
        @(posedge clk); #1;
        in_valid16 = 0; a16 = 16'($urandom); b16 = 16'($urandom); sub16 = 1'($urandom);
        lat = -1;
        for (int i = 1; i <= 80; i++) begin
            @(posedge clk); #1;
            if (out_valid16) begin lat = i; break; end
        end
    endtask

    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic sv, output int lat);
        a8 = av; b8 = bv; sub8 = sv; in_valid8 = 1;
        @(posedge clk); #1;
        in_valid8 = 0; a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
        lat = -1;
        for (int i = 1; i <= 80; i++) begin
            @(posedge clk); #1;
            if (out_valid8) begin lat = i; break; end
        end
    endtask

    task automatic op32(input logic [31:0] av, input logic [31:0] bv, input logic sv, output int lat);
        a32 = av; b32 = bv; sub32 = sv; in_valid32 = 1;
        @(posedge clk); #1;
        in_valid32 = 0; a32 = $urandom; b32 = $urandom; sub32 = 1'($urandom);
        lat = -1;
        for (int i = 1; i <= 80; i++) begin
            @(posedge clk); #1;
            if (out_valid32) begin lat = i; break; end
        end
    endtask

    task automatic test_reset;
        rst = 1; in_valid16 = 1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (in_ready16 !== 1'b0) begin fails++; $display("[TB] FAIL reset_in_ready: got %b, expected 0", in_ready16); end
        tests++;
        if ({out_valid16, result16, cout16, ovf16, zero16} !== 20'd0) begin
            fails++; $display("[TB] FAIL reset_outputs: got %b %h %b%b%b, expected 0 0000 000",
                              out_valid16, result16, cout16, ovf16, zero16);
        end
        in_valid16 = 0;
        rst = 0;
        #1;
        tests++;
        if (in_ready16 !== 1'b1) begin fails++; $display("[TB] FAIL idle_after_reset: got %b, expected 1", in_ready16); end
        @(posedge clk); #1;
    endtask

    task automatic test_add;
        int lat;
        out_ready16 = 1;
        op16(16'h1234, 16'h0FCD, 1'b0, lat);
        tests++;
        if (lat !== 4) begin fails++; $display("[TB] FAIL add_latency: got %0d, expected 4", lat); end
        tests++;
        if ({result16, cout16, ovf16, zero16} !== {16'h2201, 3'b000}) begin
            fails++; $display("[TB] FAIL add_result: got %h %b%b%b, expected 2201 000", result16, cout16, ovf16, zero16);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sub;
        int lat;
        op16(16'h0005, 16'h0007, 1'b1, lat);
        tests++;
        if ({lat, result16, cout16, ovf16, zero16} !== {32'd4, 16'hFFFE, 3'b000}) begin
            fails++; $display("[TB] FAIL sub_result: got lat %0d %h %b%b%b, expected lat 4 fffe 000",
                              lat, result16, cout16, ovf16, zero16);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_overflow;
        int lat;
        logic [15:0] exp_res;
`ifdef ADDSUB_SAT_EN
        exp_res = 16'h7FFF;
`else
        exp_res = 16'h8000;
`endif
        op16(16'h7FFF, 16'h0001, 1'b0, lat);
        tests++;
        if ({ovf16, cout16} !== 2'b10) begin fails++; $display("[TB] FAIL ovf_flags: got ovf %b cout %b, expected ovf 1 cout 0", ovf16, cout16); end
        tests++;
        if ({result16, zero16} !== {exp_res, 1'b0}) begin
            fails++; $display("[TB] FAIL ovf_result: got %h zero %b, expected %h zero 0", result16, zero16, exp_res);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        int lat;
        out_ready16 = 0;
        op16(16'h8000, 16'h8000, 1'b1, lat);
        tests++;
        if (lat !== 4) begin fails++; $display("[TB] FAIL bp_latency: got %0d, expected 4", lat); end
        for (int c = 0; c < 3; c++) begin
            tests++;
            if ({out_valid16, in_ready16, result16, zero16, cout16, ovf16} !== {2'b10, 16'h0000, 3'b110}) begin
                fails++; $display("[TB] FAIL bp_hold cycle %0d: got v%b r%b %h z%b c%b o%b, expected v1 r0 0000 z1 c1 o0",
                                  c, out_valid16, in_ready16, result16, zero16, cout16, ovf16);
            end
            if (c < 2) begin @(posedge clk); #1; end
        end
        out_ready16 = 1;
        @(posedge clk); #1;
        tests++;
        if ({out_valid16, in_ready16} !== 2'b01) begin
            fails++; $display("[TB] FAIL bp_release: got valid %b ready %b, expected valid 0 ready 1", out_valid16, in_ready16);
        end
    endtask

    task automatic test_reset_mid_run;
        int lat;
        bit seen;
        out_ready16 = 1;
        a16 = 16'h4444; b16 = 16'h1111; sub16 = 0; in_valid16 = 1;
        @(posedge clk); #1;
        in_valid16 = 0;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        #1;
        tests++;
        if ({in_ready16, out_valid16} !== 2'b10) begin
            fails++; $display("[TB] FAIL abort_idle: got ready %b valid %b, expected ready 1 valid 0", in_ready16, out_valid16);
        end
        seen = 0;
        repeat (6) begin @(posedge clk); #1; if (out_valid16) seen = 1; end
        tests++;
        if (seen !== 1'b0) begin fails++; $display("[TB] FAIL abort_no_valid: got %b, expected 0", seen); end
        op16(16'h0001, 16'h0001, 1'b0, lat);
        tests++;
        if ({lat, result16, cout16, ovf16, zero16} !== {32'd4, 16'h0002, 3'b000}) begin
            fails++; $display("[TB] FAIL after_abort: got lat %0d %h %b%b%b, expected lat 4 0002 000",
                              lat, result16, cout16, ovf16, zero16);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random16;
        int lat, hold;
        logic [15:0] av, bv, held;
        logic sv;
        longint unsigned er;
        bit ec, eo, ez;
        for (int n = 0; n < 20; n++) begin
            av = 16'($urandom); bv = 16'($urandom); sv = 1'($urandom);
            if (n < 4) bv = (n[0]) ? 16'h8000 : 16'h7FFF;
            hold = $urandom_range(0, 2);
            out_ready16 = (hold == 0);
            model(16, longint'(av), longint'(bv), sv, er, ec, eo, ez);
            op16(av, bv, sv, lat);
            tests++;
            if ({lat, result16, cout16, ovf16, zero16} !== {32'd4, er[15:0], ec, eo, ez}) begin
                fails++; $display("[TB] FAIL rand16 %h%s%h: got lat %0d %h %b%b%b, expected lat 4 %h %b%b%b",
                                  av, sv ? "-" : "+", bv, lat, result16, cout16, ovf16, zero16, er[15:0], ec, eo, ez);
            end
            held = result16;
            if (hold > 0) begin
                repeat (hold) begin @(posedge clk); #1; end
                tests++;
                if ({out_valid16, result16} !== {1'b1, held}) begin
                    fails++; $display("[TB] FAIL rand16_hold: got valid %b %h, expected valid 1 %h", out_valid16, result16, held);
                end
                out_ready16 = 1;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sweep_w8;
        int lat;
        logic [7:0] av, bv;
        logic sv;
        longint unsigned er;
        bit ec, eo, ez;
        for (int n = 0; n < 20; n++) begin
            av = 8'($urandom); bv = 8'($urandom); sv = 1'($urandom);
            if (n == 0) begin av = 8'h7F; bv = 8'h01; sv = 0; end
            if (n == 1) begin av = 8'h80; bv = 8'h01; sv = 1; end
            if (n == 2) begin av = 8'h33; bv = 8'h33; sv = 1; end
            model(8, longint'(av), longint'(bv), sv, er, ec, eo, ez);
            op8(av, bv, sv, lat);
            tests++;
            if ({lat, result8, cout8, ovf8, zero8} !== {32'd1, er[7:0], ec, eo, ez}) begin
                fails++; $display("[TB] FAIL sweep8 %h%s%h: got lat %0d %h %b%b%b, expected lat 1 %h %b%b%b",
                                  av, sv ? "-" : "+", bv, lat, result8, cout8, ovf8, zero8, er[7:0], ec, eo, ez);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sweep_w32;
        int lat;
        logic [31:0] av, bv;
        logic sv;
        longint unsigned er;
        bit ec, eo, ez;
        for (int n = 0; n < 12; n++) begin
            av = $urandom; bv = $urandom; sv = 1'($urandom);
            if (n == 0) begin av = 32'h7FFF_FFFF; bv = 32'h0000_0001; sv = 0; end
            if (n == 1) begin av = 32'h8000_0000; bv = 32'h0000_0001; sv = 1; end
            if (n == 2) begin av = 32'hDEAD_BEEF; bv = 32'hDEAD_BEEF; sv = 1; end
            model(32, longint'(av), longint'(bv), sv, er, ec, eo, ez);
            op32(av, bv, sv, lat);
            tests++;
            if ({lat, result32, cout32, ovf32, zero32} !== {32'd32, er[31:0], ec, eo, ez}) begin
                fails++; $display("[TB] FAIL sweep32 %h%s%h: got lat %0d %h %b%b%b, expected lat 32 %h %b%b%b",
                                  av, sv ? "-" : "+", bv, lat, result32, cout32, ovf32, zero32, er[31:0], ec, eo, ez);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_overflow();
        test_backpressure();
        test_reset_mid_run();
        test_random16();
        test_sweep_w8();
        test_sweep_w32();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
